program_loader: RTL and testbench

Byte-stream program loader that writes instruction memory, the write side of the instruction path the CPU fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles INSTRUCTION_WIDTH-bit instructions and writes them sequentially from address 0. It holds the CPU in reset while a load is in progress or has failed.

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream loader bus: the upstream byte handshake plus the instruction
// memory write port and CPU control outputs.
//   inValid/inByte/inReady             : byte stream, transfer on inValid && inReady
//   writeEnable/writeAddress/writeData : instruction memory write port
//   cpuHold/done/error                 : CPU hold level, load-done pulse, failure level
// slave  : the loader side (drives inReady and all memory/status outputs)
// master : the stream source / memory observer side
interface program_loader_if #(
  parameter int PC_WIDTH          = 4,
  parameter int INSTRUCTION_WIDTH = 12
);
  logic                         inValid;
  logic [7:0]                   inByte;
  logic                         inReady;
  logic                         writeEnable;
  logic [PC_WIDTH-1:0]          writeAddress;
  logic [INSTRUCTION_WIDTH-1:0] writeData;
  logic                         cpuHold;
  logic                         done;
  logic                         error;

  modport master (
    output inValid, inByte,
    input  inReady, writeEnable, writeAddress, writeData, cpuHold, done, error
  );

  modport slave (
    input  inValid, inByte,
    output inReady, writeEnable, writeAddress, writeData, cpuHold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream program loader. Accepts HEADER, count N, N two-byte
// instructions (high nibble byte, low byte) and an XOR checksum, writing each
// instruction to instruction memory from address 0 upward. The CPU is held in
// reset from header acceptance until a frame completes successfully.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : program_loader_if.slave (stream in, memory write port, status out)
module program_loader #(
  parameter int          PC_WIDTH          = 4,
  parameter int          INSTRUCTION_WIDTH = 12,
  parameter logic [7:0]  HEADER            = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  program_loader_if.slave   bus
);

  // Largest legal count: memory capacity, limited to what fits in the count byte.
  localparam logic [8:0] MAX_N = (PC_WIDTH >= 8) ? 9'd255 : 9'(1 << PC_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HIGH, S_LOW, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                       r_state, w_next;
  logic [7:0]                   r_count;
  logic [7:0]                   r_xor;
  logic [3:0]                   r_nibble;
  logic [PC_WIDTH-1:0]          r_index;

  logic                         r_we, r_hold, r_done, r_err;
  logic [PC_WIDTH-1:0]          r_addr;
  logic [INSTRUCTION_WIDTH-1:0] r_data;

  logic                         w_ready, w_fire, w_more;
  logic                         w_we_nxt, w_hold_nxt, w_done_nxt, w_err_nxt;
  logic [PC_WIDTH-1:0]          w_addr_nxt;
  logic [INSTRUCTION_WIDTH-1:0] w_data_nxt;

  assign w_ready = (r_state != S_WRITE);
  assign w_fire  = bus.inValid && w_ready;
  // Writes completed after the current WRITE cycle is r_index + 1.
  assign w_more  = (9'(r_index) + 9'd1) < {1'b0, r_count};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERROR:
        if (w_fire && bus.inByte == HEADER) w_next = S_COUNT;
      S_COUNT:
        if (w_fire)
          w_next = (bus.inByte == 8'd0 || {1'b0, bus.inByte} > MAX_N) ? S_ERROR : S_HIGH;
      S_HIGH:
        if (w_fire) w_next = (bus.inByte[7:4] != 4'd0) ? S_ERROR : S_LOW;
      S_LOW:
        if (w_fire) w_next = S_WRITE;
      S_WRITE:
        w_next = w_more ? S_HIGH : S_CHECK;
      S_CHECK:
        if (w_fire) w_next = (bus.inByte == r_xor) ? S_DONE : S_ERROR;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state; the write
  // word is captured straight from the low byte on the edge that accepts it.
  always_comb begin
    w_we_nxt   = (w_next == S_WRITE);
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    if (w_next == S_WRITE) begin
      w_addr_nxt = r_index;
      w_data_nxt = INSTRUCTION_WIDTH'({r_nibble, bus.inByte});
    end
    w_hold_nxt = (w_next != S_IDLE);
    w_done_nxt = (w_next == S_DONE);
    w_err_nxt  = (w_next == S_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_hold <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_we   <= w_we_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
      r_hold <= w_hold_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_xor    <= '0;
      r_nibble <= '0;
      r_index  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR:
          if (w_fire && bus.inByte == HEADER) begin
            r_index <= '0;
            r_xor   <= '0;
          end
        S_COUNT:
          if (w_fire) r_count <= bus.inByte;
        S_HIGH:
          if (w_fire && bus.inByte[7:4] == 4'd0) begin
            r_nibble <= bus.inByte[3:0];
            r_xor    <= r_xor ^ bus.inByte;
          end
        S_LOW:
          if (w_fire) r_xor <= r_xor ^ bus.inByte;
        S_WRITE:
          if (w_more) r_index <= r_index + PC_WIDTH'(1);
        default: ;
      endcase
    end
  end

  assign bus.inReady      = w_ready;
  assign bus.writeEnable  = r_we;
  assign bus.writeAddress = r_addr;
  assign bus.writeData    = r_data;
  assign bus.cpuHold      = r_hold;
  assign bus.done         = r_done;
  assign bus.error        = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued as
// frames are driven and compared when the write strobe is observed.
module tb_program_loader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  program_loader_if #(.PC_WIDTH(4), .INSTRUCTION_WIDTH(12)) bus ();

  program_loader #(.PC_WIDTH(4), .INSTRUCTION_WIDTH(12), .HEADER(8'hA5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  int wr_cnt = 0, done_cnt = 0, rdy_low_cnt = 0;
  logic [11:0] prog[16];
  // {inReady, writeEnable, writeAddress, writeData, cpuHold, done, error}
  localparam logic [20:0] RESET_VEC = {1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0};

  function automatic logic [20:0] out_vec();
    return {bus.inReady, bus.writeEnable, bus.writeAddress, bus.writeData,
            bus.cpuHold, bus.done, bus.error};
  endfunction

  // Write monitor / scoreboard consumer
  always @(negedge clock) begin
    logic [15:0] e;
    if (!reset) begin
      if (!bus.inReady) rdy_low_cnt++;
      if (bus.done) done_cnt++;
      if (bus.writeEnable) begin
        wr_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got addr %0d data %03h, expected no write",
                   bus.writeAddress, bus.writeData);
        end else begin
          e = exp_q.pop_front();
          if ({bus.writeAddress, bus.writeData} !== e) begin
            n_fail++;
            $display("FAIL write_word: got addr %0d data %03h, expected addr %0d data %03h",
                     bus.writeAddress, bus.writeData, e[15:12], e[11:0]);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      bus.inValid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    bus.inValid = 1'b1;
    bus.inByte  = b;
    guard = 0;
    while (!bus.inReady && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.inReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: inReady stayed 0 for byte %02h, expected 1", b);
    end
    @(negedge clock);
  endtask

  // Drives a full frame of prog[0..n-1]; cks_flip corrupts the checksum byte.
  task automatic send_program(input int n, input int max_gap, input logic [7:0] cks_flip);
    logic [7:0] cks;
    cks = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'(n), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'(i), prog[i]});
      cks = cks ^ {4'h0, prog[i][11:8]} ^ prog[i][7:0];
      send_byte({4'h0, prog[i][11:8]}, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      send_byte(prog[i][7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    send_byte(cks ^ cks_flip, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    bus.inValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.inByte  = 8'h00;
    #1;
    n_checks++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected %h", out_vec(), RESET_VEC);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, expected %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_load();
    int w0, d0, r0;
    w0 = wr_cnt; d0 = done_cnt; r0 = rdy_low_cnt;
    send_byte(8'hA5, 0);
    n_checks++;
    if (bus.cpuHold !== 1'b1) begin
      n_fail++;
      $display("FAIL load_hold_rise: got cpuHold %b, expected 1", bus.cpuHold);
    end
    send_byte(8'h02, 0);
    exp_q.push_back({4'd0, 12'h123});
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    exp_q.push_back({4'd1, 12'hE00});
    send_byte(8'h0E, 0);
    send_byte(8'h00, 0);
    send_byte(8'h2C, 0);
    bus.inValid = 1'b0;
    n_checks++;
    if ({bus.done, bus.cpuHold, bus.error} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_done_state: got done/hold/err %b%b%b, expected 110",
               bus.done, bus.cpuHold, bus.error);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.done, bus.cpuHold, bus.error} !== 3'b000) begin
      n_fail++;
      $display("FAIL load_release: got done/hold/err %b%b%b, expected 000",
               bus.done, bus.cpuHold, bus.error);
    end
    n_checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1 || rdy_low_cnt - r0 !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL load_counts: got writes %0d done %0d stall %0d pending %0d, expected 2 1 2 0",
               wr_cnt - w0, done_cnt - d0, rdy_low_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_checksum();
    int w0, d0;
    prog[0] = 12'h123;
    prog[1] = 12'hE00;
    w0 = wr_cnt; d0 = done_cnt;
    send_program(2, 0, 8'h01);
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.error, bus.cpuHold} !== 2'b11 || wr_cnt - w0 !== 2 || done_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL cks_error: got err %b hold %b writes %0d done %0d, expected 1 1 2 0",
               bus.error, bus.cpuHold, wr_cnt - w0, done_cnt - d0);
    end
    d0 = done_cnt;
    send_program(2, 0, 8'h00);
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.error, bus.cpuHold} !== 2'b00 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL cks_recover: got err %b hold %b done %0d, expected 0 0 1",
               bus.error, bus.cpuHold, done_cnt - d0);
    end
  endtask

  task automatic test_bad_high();
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hF1, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 1);
    send_byte(8'h34, 0);
    bus.inValid = 1'b0;
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.error, bus.cpuHold, bus.inReady} !== 3'b111 || wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL bad_high: got err %b hold %b ready %b writes %0d, expected 1 1 1 0",
               bus.error, bus.cpuHold, bus.inReady, wr_cnt - w0);
    end
  endtask

  task automatic test_count_bounds();
    int d0;
    time t0, t1;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    bus.inValid = 1'b0;
    n_checks++;
    if (bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL count_zero: got error %b, expected 1", bus.error);
    end
    send_byte(8'hA5, 0);
    n_checks++;
    if (bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL header_clears_error: got error %b, expected 0", bus.error);
    end
    send_byte(8'h11, 0);
    bus.inValid = 1'b0;
    n_checks++;
    if (bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL count_over: got error %b, expected 1", bus.error);
    end
    for (int i = 0; i < 16; i++) prog[i] = 12'($urandom);
    prog[3]  = 12'h0A5;   // header value as in-frame data
    prog[15] = 12'hFFF;
    d0 = done_cnt;
    @(negedge clock);
    t0 = $time;
    send_program(16, 0, 8'h00);
    t1 = $time;
    n_checks++;
    if ((t1 - t0) / 10 !== 51 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_frame_time: got %0d cycles done %b, expected 51 1", (t1 - t0) / 10, bus.done);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || bus.cpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame_end: got done %0d pending %0d hold %b, expected 1 0 0",
               done_cnt - d0, exp_q.size(), bus.cpuHold);
    end
  endtask

  task automatic test_gaps();
    int w0, d0, r0;
    for (int i = 0; i < 5; i++) prog[i] = 12'($urandom);
    w0 = wr_cnt; d0 = done_cnt; r0 = rdy_low_cnt;
    send_program(5, 3, 8'h00);
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (rdy_low_cnt - r0 !== 5 || wr_cnt - w0 !== 5 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL gap_frame: got stall %0d writes %0d done %0d pending %0d, expected 5 5 1 0",
               rdy_low_cnt - r0, wr_cnt - w0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int w0, d0;
    w0 = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h03, 0);
    bus.inValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h, expected %h", out_vec(), RESET_VEC);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h03, 0);
    bus.inValid = 1'b0;
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.cpuHold, bus.error} !== 2'b00 || wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL post_reset_drop: got hold %b err %b writes %0d, expected 0 0 0",
               bus.cpuHold, bus.error, wr_cnt - w0);
    end
    prog[0] = 12'h5A5;
    d0 = done_cnt;
    send_program(1, 0, 8'h00);
    @(negedge clock);
    #1;
    n_checks++;
    if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL post_reset_load: got done %0d writes %0d pending %0d, expected 1 1 0",
               done_cnt - d0, wr_cnt - w0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_checksum();
    test_bad_high();
    test_count_bounds();
    test_gaps();
    test_async_reset();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
